// File: rtl/alu_sequencer.sv
// Four-phase controller (IDLE/DECODE/EXECUTE/WRITEBACK) that steps the core ALU one instruction at a time.
// Optional HALT opcode (all-ones) and terminal HALTED state when ALU_SEQUENCER_HALT_EN is defined.
module alu_sequencer #(
    parameter int OPCODE_WIDTH   = 4,
    parameter int REGISTER_WIDTH = 8,
    parameter int ADDRESS_WIDTH  = 3,
    parameter logic [OPCODE_WIDTH-1:0] OP_ADD   = 4'd2,
    parameter logic [OPCODE_WIDTH-1:0] OP_INC   = 4'd11,
    parameter logic [OPCODE_WIDTH-1:0] OP_STORE = 4'd7,
    parameter logic [OPCODE_WIDTH-1:0] OP_NOP   = 4'd0
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    instrValid,
    output logic                                    instrReady,
    input  logic [OPCODE_WIDTH+2*ADDRESS_WIDTH-1:0] instruction,
    output logic [ADDRESS_WIDTH-1:0]                register0Address,
    output logic [ADDRESS_WIDTH-1:0]                register1Address,
    input  logic [REGISTER_WIDTH-1:0]               register0Value,
    input  logic [REGISTER_WIDTH-1:0]               register1Value,
    output logic [OPCODE_WIDTH-1:0]                 aluOpCode,
    input  logic [REGISTER_WIDTH-1:0]               aluResult,
    output logic [REGISTER_WIDTH-1:0]               accumulator,
    output logic                                    regWriteEnable,
    output logic [ADDRESS_WIDTH-1:0]                regWriteAddress,
    output logic [REGISTER_WIDTH-1:0]               regWriteData,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    halted
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
`ifdef ALU_SEQUENCER_HALT_EN
    localparam logic [2:0] S_HALTED    = 3'd4;
`endif

    logic [2:0]                r_state;
    logic [2:0]                w_state_next;
    logic [OPCODE_WIDTH-1:0]   r_opcode;
    logic [ADDRESS_WIDTH-1:0]  r_reg0_addr;
    logic [ADDRESS_WIDTH-1:0]  r_reg1_addr;
    logic [REGISTER_WIDTH-1:0] r_acc;
    logic                      w_accept;
    logic                      w_acc_load;

    // Read data is consumed by the ALU, not by the sequencer itself.
    logic w_unused_read_data;
    assign w_unused_read_data = ^{register0Value, register1Value};

    assign w_accept   = instrValid && instrReady;
    assign w_acc_load = (r_state == S_EXECUTE) && ((r_opcode == OP_ADD) || (r_opcode == OP_INC));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_state_next = S_DECODE;
            S_DECODE:    w_state_next = S_EXECUTE;
            S_EXECUTE:   w_state_next = S_WRITEBACK;
            S_WRITEBACK: begin
                w_state_next = S_IDLE;
`ifdef ALU_SEQUENCER_HALT_EN
                if (r_opcode == {OPCODE_WIDTH{1'b1}}) w_state_next = S_HALTED;
`endif
            end
`ifdef ALU_SEQUENCER_HALT_EN
            S_HALTED:    w_state_next = S_HALTED;
`endif
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_reg0_addr <= '0;
            r_reg1_addr <= '0;
            r_acc       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_opcode    <= instruction[OPCODE_WIDTH+2*ADDRESS_WIDTH-1 -: OPCODE_WIDTH];
                r_reg0_addr <= instruction[2*ADDRESS_WIDTH-1 -: ADDRESS_WIDTH];
                r_reg1_addr <= instruction[ADDRESS_WIDTH-1:0];
            end
            if (w_acc_load) r_acc <= aluResult;
        end
    end

    assign instrReady       = (r_state == S_IDLE);
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_WRITEBACK);
    assign aluOpCode        = (r_state == S_EXECUTE) ? r_opcode : OP_NOP;
    assign register0Address = r_reg0_addr;
    assign register1Address = r_reg1_addr;
    assign accumulator      = r_acc;
    assign regWriteEnable   = (r_state == S_WRITEBACK) && (r_opcode == OP_STORE);
    assign regWriteAddress  = r_reg0_addr;
    assign regWriteData     = r_acc;

`ifdef ALU_SEQUENCER_HALT_EN
    assign halted = (r_state == S_HALTED);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the core's combinational ALU.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives the register-file read addresses and the ALU opcode, owns the accumulator register, and issues register-file writes.
- Sits between the instruction source and the ALU / register file.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field and of aluOpCode.
- REGISTER_WIDTH, 8, datapath width (accumulator, register values, ALU result).
- ADDRESS_WIDTH, 3, register-file address width.
- OP_ADD, 2, opcode: accumulator <= reg0 + reg1.
- OP_INC, 11, opcode: accumulator <= accumulator + 1.
- OP_STORE, 7, opcode: register[reg0Address] <= accumulator.
- OP_NOP, 0, opcode driven to the ALU when idle (pass-through).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- instrValid  input  1  instruction present.
- instrReady  output  1  sequencer can accept an instruction.
- instruction  input  OPCODE_WIDTH+2*ADDRESS_WIDTH  fields, MSB to LSB: opcode, reg0Address, reg1Address.
- register0Address  output  ADDRESS_WIDTH  register-file read port 0 address.
- register1Address  output  ADDRESS_WIDTH  register-file read port 1 address.
- register0Value  input  REGISTER_WIDTH  combinational read data, port 0 (informational; consumed by ALU).
- register1Value  input  REGISTER_WIDTH  combinational read data, port 1 (informational).
- aluOpCode  output  OPCODE_WIDTH  opcode to the ALU.
- aluResult  input  REGISTER_WIDTH  ALU output.
- accumulator  output  REGISTER_WIDTH  accumulator register; also feeds the ALU.
- regWriteEnable  output  1  register-file write strobe.
- regWriteAddress  output  ADDRESS_WIDTH  write address.
- regWriteData  output  REGISTER_WIDTH  write data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when an instruction retires.
- halted  output  1  sequencer halted (see Optional Feature).

Behaviour:
- Reset values: state IDLE, accumulator 0, latched opcode and addresses 0, instrReady 1, busy 0, done 0, regWriteEnable 0, aluOpCode OP_NOP, halted 0.
- Reset asserted in any state aborts the instruction: no write, no done, accumulator cleared.
- IDLE:
  - instrReady = 1.
  - On instrValid && instrReady, latch opcode, reg0Address and reg1Address, then go to DECODE.
  - Otherwise stay in IDLE.
- DECODE:
  - register0Address and register1Address driven from the latched fields; they hold until the next accept.
  - aluOpCode = OP_NOP.
  - Go to EXECUTE.
- EXECUTE:
  - aluOpCode = latched opcode.
  - On the exit edge, accumulator <= aluResult if the opcode is OP_ADD or OP_INC; otherwise unchanged.
  - Go to WRITEBACK.
- WRITEBACK:
  - aluOpCode = OP_NOP; done = 1.
  - If the opcode is OP_STORE: regWriteEnable = 1, regWriteAddress = reg0Address, regWriteData = accumulator.
  - Go to IDLE.
- Timing: instrReady is low in DECODE, EXECUTE and WRITEBACK; instrValid is ignored there.
- Throughput and latency: one instruction per 4 cycles; done is asserted 3 cycles after the accept edge.
- Arithmetic is modulo 2^REGISTER_WIDTH; carry is discarded.
  - INC: 0xFF -> 0x00.
  - ADD: 0xF0 + 0x20 = 0x10.
- Unknown opcodes behave as NOP: same 4-cycle sequence, done pulses, accumulator unchanged, no write.
- A back-to-back accept is possible in the IDLE cycle immediately after WRITEBACK.
- regWriteAddress and regWriteData are don't-care when regWriteEnable = 0.

Optional Feature:
- Macro: ALU_SEQUENCER_HALT_EN.
- Defined:
  - Opcode all-ones (15 at default width) is HALT.
  - After its WRITEBACK (done pulses), enter HALTED.
  - In HALTED: instrReady = 0, busy = 1, halted = 1. Only reset exits.
- Undefined:
  - Opcode all-ones is an ordinary NOP.
  - halted is tied to 0; the HALTED state does not exist.

Test Plan:
- Reset, then idle 5 cycles -> accumulator 0, instrReady 1, busy 0, done 0, aluOpCode 0, regWriteEnable 0.
- Accept ADD r1,r2 with register values 0x12 and 0x34 -> aluOpCode = 2 in EXECUTE only; accumulator 0x46; done 3 cycles after accept.
- Accumulator 0xFF, accept INC -> accumulator 0x00; no write; instrValid held high through busy accepts nothing until IDLE.
- Accumulator 0x5A, accept STORE r5 -> single WRITEBACK cycle with regWriteEnable 1, address 5, data 0x5A.
- Accept ADD, assert reset in EXECUTE -> next cycle IDLE, accumulator 0, no done, no write.
- With ALU_SEQUENCER_HALT_EN defined, accept opcode 15, then offer INC -> halted 1, instrReady 0, INC never accepted; reset -> halted 0.
